// File: rtl/rregfile_pkg.sv
// Shared definitions for the rregfile general-purpose register bank:
// default geometry, the all-zeros word, the word type and the address
// range check used by the write decoder.
package rregfile_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_DEPTH = 32;

   localparam logic [DEFAULT_WIDTH-1:0] ZERO_WORD = '0;

   typedef logic [DEFAULT_WIDTH-1:0] word_t;

   // True when addr names a physically present word of a depth-word bank.
   function automatic logic addr_in_range(input logic [31:0] addr,
                                          input logic [31:0] depth);
      return addr < depth;
   endfunction

endpackage

// File: rtl/rword.sv
// One storage word of the register bank: a WIDTH-bit register with
// synchronous clear and a load enable.
module rword #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Clear wins over load so a write on the reset edge is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (enable) begin
         q <= d;
      end
   end

endmodule

// File: rtl/rregfile.sv
// CPU general-purpose register bank: DEPTH words of WIDTH bits, one
// synchronous write port and two combinational read ports.
// Entry 0 is hardwired to zero when ZERO_REG=1; addresses at or above
// DEPTH ignore writes and read as zero.
// Optional macro RREGFILE_WRITE_BYPASS_EN forwards the write data to a
// read port addressing the word being written in the same cycle.
module rregfile
   import rregfile_pkg::*;
#(
   parameter  int WIDTH    = DEFAULT_WIDTH,
   parameter  int DEPTH    = DEFAULT_DEPTH,
   parameter  int ZERO_REG = 1,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr1,
   output logic [WIDTH-1:0] rdata1,
   input  logic [AW-1:0]    raddr2,
   output logic [WIDTH-1:0] rdata2
);

   // Every encodable address gets a slot so the read mux needs no
   // range check: missing words and the zero entry are tied to zero.
   localparam int NUM_SLOTS = 1 << AW;

   logic [WIDTH-1:0] slot [NUM_SLOTS];
   logic             waddr_ok;

   assign waddr_ok = addr_in_range(32'(waddr), 32'(DEPTH)) &&
                     !((ZERO_REG != 0) && (waddr == '0));

   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      if ((i >= DEPTH) || ((ZERO_REG != 0) && (i == 0))) begin : g_zero
         assign slot[i] = WIDTH'(ZERO_WORD);
      end else begin : g_word
         logic en;
         assign en = we && waddr_ok && (waddr == AW'(i));
         rword #(
            .WIDTH (WIDTH)
         ) u_word (
            .clk    (clk),
            .reset  (reset),
            .enable (en),
            .d      (wdata),
            .q      (slot[i])
         );
      end
   end

   // Both read ports select from the slot table, optionally forwarding write data.
   always_comb begin
      rdata1 = slot[raddr1];
      rdata2 = slot[raddr2];
`ifdef RREGFILE_WRITE_BYPASS_EN
      if (we && !reset && waddr_ok && (raddr1 == waddr)) begin
         rdata1 = wdata;
      end
      if (we && !reset && waddr_ok && (raddr2 == waddr)) begin
         rdata2 = wdata;
      end
`endif
   end

endmodule

// File: tb/tb_rregfile.sv
// Testbench for rregfile: three instances share one stimulus stream
// (32 deep with zero entry, 24 deep with zero entry, 32 deep without)
// and are compared against an array-based reference model.
module tb_rregfile;
   import rregfile_pkg::*;

   localparam int NDUT = 3;

   logic        clk    = 1'b0;
   logic        reset  = 1'b1;
   logic        we     = 1'b0;
   logic [4:0]  waddr  = '0;
   logic [31:0] wdata  = '0;
   logic [4:0]  raddr1 = '0;
   logic [4:0]  raddr2 = '0;
   logic [31:0] rd1 [NDUT];
   logic [31:0] rd2 [NDUT];

   int    depth_of [NDUT] = '{32, 24, 32};
   int    zreg_of  [NDUT] = '{1, 1, 0};
   word_t mem [NDUT][32];

   int checks   = 0;
   int failures = 0;

   rregfile #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) dut_a (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .rdata1(rd1[0]), .raddr2(raddr2), .rdata2(rd2[0]));

   rregfile #(.WIDTH(32), .DEPTH(24), .ZERO_REG(1)) dut_b (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .rdata1(rd1[1]), .raddr2(raddr2), .rdata2(rd2[1]));

   rregfile #(.WIDTH(32), .DEPTH(32), .ZERO_REG(0)) dut_c (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .rdata1(rd1[2]), .raddr2(raddr2), .rdata2(rd2[2]));

   always #5 clk = ~clk;

   function automatic logic writable(int d, int a);
      return (a < depth_of[d]) && !((zreg_of[d] != 0) && (a == 0));
   endfunction

   // Reference bank: cleared by reset, otherwise one legal write per edge.
   always @(posedge clk) begin
      for (int d = 0; d < NDUT; d++) begin
         if (reset) begin
            for (int a = 0; a < 32; a++) mem[d][a] = ZERO_WORD;
         end else if (we && writable(d, int'(waddr))) begin
            mem[d][waddr] = wdata;
         end
      end
   end

   function automatic word_t model_read(int d, int a);
      if (a >= depth_of[d] || ((zreg_of[d] != 0) && a == 0)) return ZERO_WORD;
`ifdef RREGFILE_WRITE_BYPASS_EN
      if (we === 1'b1 && reset === 1'b0 && a == int'(waddr) && writable(d, a)) return wdata;
`endif
      return mem[d][a];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 32'hCAFE_0004;
      step(); step();
      reset = 1'b0; we = 1'b0;
      for (int a = 0; a < 32; a++) begin
         raddr1 = 5'(a); raddr2 = 5'(31 - a); #1;
         for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (rd1[d] !== 32'h0) begin
               failures++;
               $display("[TB] FAIL reset_rd1 dut=%0d addr=%0d got=%h exp=%h", d, a, rd1[d], 32'h0);
            end
            checks++;
            if (rd2[d] !== 32'h0) begin
               failures++;
               $display("[TB] FAIL reset_rd2 dut=%0d addr=%0d got=%h exp=%h", d, 31 - a, rd2[d], 32'h0);
            end
         end
      end
   endtask

   task automatic test_reset_clear();
      we = 1'b1;
      for (int i = 0; i < 32; i++) begin
         waddr = 5'(i); wdata = 32'hA5A5_0000 + 32'(i);
         step();
      end
      we = 1'b0; raddr1 = 5'd9; raddr2 = 5'd31; #1;
      checks++;
      if (rd1[0] !== 32'hA5A5_0009) begin
         failures++;
         $display("[TB] FAIL fill_rd1 dut=0 addr=9 got=%h exp=%h", rd1[0], 32'hA5A5_0009);
      end
      checks++;
      if (rd2[2] !== 32'hA5A5_001F) begin
         failures++;
         $display("[TB] FAIL fill_rd2 dut=2 addr=31 got=%h exp=%h", rd2[2], 32'hA5A5_001F);
      end
      reset = 1'b1; step(); reset = 1'b0;
      for (int a = 0; a < 32; a++) begin
         raddr1 = 5'(a); raddr2 = 5'(a); #1;
         for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (rd1[d] !== 32'h0 || rd2[d] !== 32'h0) begin
               failures++;
               $display("[TB] FAIL clear dut=%0d addr=%0d got=%h/%h exp=%h", d, a, rd1[d], rd2[d], 32'h0);
            end
         end
      end
   endtask

   task automatic test_write_latency();
      we = 1'b1; waddr = 5'd5; wdata = 32'h1111_0005; raddr1 = 5'd5; raddr2 = 5'd5;
      step();
      wdata = 32'hDEAD_BEEF; #1;
      for (int d = 0; d < NDUT; d++) begin
`ifdef RREGFILE_WRITE_BYPASS_EN
         checks++;
         if (rd1[d] !== 32'hDEAD_BEEF || rd2[d] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("[TB] FAIL latency_same_cycle dut=%0d got=%h/%h exp=%h", d, rd1[d], rd2[d], 32'hDEAD_BEEF);
         end
`else
         checks++;
         if (rd1[d] !== 32'h1111_0005 || rd2[d] !== 32'h1111_0005) begin
            failures++;
            $display("[TB] FAIL latency_same_cycle dut=%0d got=%h/%h exp=%h", d, rd1[d], rd2[d], 32'h1111_0005);
         end
`endif
      end
      step();
      we = 1'b0; #1;
      for (int d = 0; d < NDUT; d++) begin
         checks++;
         if (rd1[d] !== 32'hDEAD_BEEF || rd2[d] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("[TB] FAIL latency_next_cycle dut=%0d got=%h/%h exp=%h", d, rd1[d], rd2[d], 32'hDEAD_BEEF);
         end
      end
   endtask

   task automatic test_zero_entry();
      we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
      step();
      we = 1'b0; raddr1 = 5'd0; raddr2 = 5'd0; #1;
      for (int d = 0; d < NDUT; d++) begin
         logic [31:0] exp;
         exp = (zreg_of[d] != 0) ? 32'h0 : 32'hFFFF_FFFF;
         checks++;
         if (rd1[d] !== exp || rd2[d] !== exp) begin
            failures++;
            $display("[TB] FAIL zero_entry dut=%0d got=%h/%h exp=%h", d, rd1[d], rd2[d], exp);
         end
      end
   endtask

   task automatic test_reset_collision();
      we = 1'b1; waddr = 5'd3; wdata = 32'h0000_ABCD; raddr1 = 5'd3; raddr2 = 5'd3;
      step();
      reset = 1'b1; wdata = 32'h0000_1234; #1;
      for (int d = 0; d < NDUT; d++) begin
         checks++;
         if (rd1[d] !== 32'h0000_ABCD) begin
            failures++;
            $display("[TB] FAIL collision_pre dut=%0d got=%h exp=%h", d, rd1[d], 32'h0000_ABCD);
         end
      end
      step();
      reset = 1'b0; we = 1'b0; #1;
      for (int d = 0; d < NDUT; d++) begin
         checks++;
         if (rd1[d] !== 32'h0 || rd2[d] !== 32'h0) begin
            failures++;
            $display("[TB] FAIL collision_post dut=%0d got=%h/%h exp=%h", d, rd1[d], rd2[d], 32'h0);
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         reset  = ($urandom_range(0, 39) == 0);
         we     = 1'($urandom_range(0, 1));
         waddr  = 5'($urandom_range(0, 31));
         wdata  = $urandom;
         raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
         raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
         #1;
         for (int d = 0; d < NDUT; d++) begin
            word_t e1, e2;
            e1 = model_read(d, int'(raddr1));
            e2 = model_read(d, int'(raddr2));
            checks++;
            if (rd1[d] !== e1) begin
               failures++;
               $display("[TB] FAIL random_rd1 dut=%0d addr=%0d got=%h exp=%h", d, raddr1, rd1[d], e1);
            end
            checks++;
            if (rd2[d] !== e2) begin
               failures++;
               $display("[TB] FAIL random_rd2 dut=%0d addr=%0d got=%h exp=%h", d, raddr2, rd2[d], e2);
            end
         end
         step();
      end
      reset = 1'b0; we = 1'b0;
   endtask

   task automatic test_out_of_range();
      we = 1'b1; waddr = 5'd27; wdata = 32'h0000_0055;
      step();
      we = 1'b0; raddr1 = 5'd27; raddr2 = 5'd27; #1;
      checks++;
      if (rd1[1] !== 32'h0 || rd2[1] !== 32'h0) begin
         failures++;
         $display("[TB] FAIL oor_read dut=1 addr=27 got=%h/%h exp=%h", rd1[1], rd2[1], 32'h0);
      end
      checks++;
      if (rd1[0] !== 32'h0000_0055) begin
         failures++;
         $display("[TB] FAIL oor_inrange dut=0 addr=27 got=%h exp=%h", rd1[0], 32'h0000_0055);
      end
      for (int a = 0; a < 24; a++) begin
         raddr1 = 5'(a); raddr2 = 5'(23 - a); #1;
         checks++;
         if (rd1[1] !== model_read(1, a) || rd2[1] !== model_read(1, 23 - a)) begin
            failures++;
            $display("[TB] FAIL oor_unchanged dut=1 addr=%0d got=%h exp=%h", a, rd1[1], model_read(1, a));
         end
      end
   endtask

   task automatic test_bypass();
      we = 1'b1; waddr = 5'd7; wdata = 32'h0000_0011;
      step();
      wdata = 32'h0000_0077; raddr1 = 5'd7; raddr2 = 5'd8; #1;
      for (int d = 0; d < NDUT; d++) begin
`ifdef RREGFILE_WRITE_BYPASS_EN
         checks++;
         if (rd1[d] !== 32'h0000_0077) begin
            failures++;
            $display("[TB] FAIL bypass dut=%0d got=%h exp=%h", d, rd1[d], 32'h0000_0077);
         end
`else
         checks++;
         if (rd1[d] !== 32'h0000_0011) begin
            failures++;
            $display("[TB] FAIL bypass dut=%0d got=%h exp=%h", d, rd1[d], 32'h0000_0011);
         end
`endif
         checks++;
         if (rd2[d] !== model_read(d, 8)) begin
            failures++;
            $display("[TB] FAIL bypass_other_port dut=%0d got=%h exp=%h", d, rd2[d], model_read(d, 8));
         end
      end
      step();
      we = 1'b0; #1;
      for (int d = 0; d < NDUT; d++) begin
         checks++;
         if (rd1[d] !== 32'h0000_0077) begin
            failures++;
            $display("[TB] FAIL bypass_next dut=%0d got=%h exp=%h", d, rd1[d], 32'h0000_0077);
         end
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_reset_clear();
      test_write_latency();
      test_zero_entry();
      test_reset_collision();
      test_random();
      test_out_of_range();
      test_bypass();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
